// File: rtl/target_feeder.sv
// target_feeder: latches a 256-bit target and writes it into the target FIFO as eight 32-bit words, least-significant word first.
// It then pulses start, watches the comparator run and drains it with stop/stop_ack_comp.
// Define TARGET_FEEDER_TIMEOUT_EN to add the optional RUN-state timeout.
module target_feeder #(
    parameter int          START_DELAY    = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] target_in,
    input  logic         target_valid,
    output logic         target_ready,
    input  logic         abort,
    output logic         target_fifo_we,
    output logic [31:0]  target_fifo_wdata,
    input  logic         target_fifo_full,
    output logic         start,
    output logic         stop,
    input  logic         stop_ack_comp,
    input  logic         result,
    output logic         found,
    output logic         timeout,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PUSH  = 3'd1,
        S_DELAY = 3'd2,
        S_START = 3'd3,
        S_RUN   = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    localparam logic [7:0] DELAY_LAST = 8'(START_DELAY - 1);

    state_t       state_r;
    state_t       state_nx_s;
    logic [255:0] target_r;
    logic [2:0]   wcnt_r;
    logic [7:0]   dcnt_r;
    logic         stop_min_r;
    logic         result_prev_r;
    logic         found_r;
    logic         load_s;
    logic         wr_s;
    logic         hit_s;
    logic         rise_s;
    logic         tmo_hit_s;

    // A hit is only a fresh 0->1 edge; a result left high by an earlier job does not count.
    assign rise_s = result & ~result_prev_r;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode and per-cycle strobes
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        wr_s       = 1'b0;
        hit_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (target_valid) begin
                    load_s     = 1'b1;
                    state_nx_s = S_PUSH;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_PUSH: begin
                wr_s = ~target_fifo_full;
                if (abort) begin
                    state_nx_s = S_STOP;
                end else if (wr_s && (wcnt_r == 3'd7)) begin
                    state_nx_s = S_DELAY;
                end else begin
                    state_nx_s = S_PUSH;
                end
            end
            S_DELAY: begin
                if (abort) begin
                    state_nx_s = S_STOP;
                end else if (dcnt_r == DELAY_LAST) begin
                    state_nx_s = S_START;
                end else begin
                    state_nx_s = S_DELAY;
                end
            end
            S_START: begin
                state_nx_s = S_RUN;
            end
            S_RUN: begin
                // A hit outranks a simultaneous abort, and abort outranks timeout.
                if (rise_s) begin
                    hit_s      = 1'b1;
                    state_nx_s = S_STOP;
                end else if (abort) begin
                    state_nx_s = S_STOP;
                end else if (tmo_hit_s) begin
                    state_nx_s = S_STOP;
                end else begin
                    state_nx_s = S_RUN;
                end
            end
            S_STOP: begin
                if (stop_min_r && stop_ack_comp) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_STOP;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // Target latch, word/delay counters, stop minimum-length flag and sticky hit status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_r      <= 256'd0;
            wcnt_r        <= 3'd0;
            dcnt_r        <= 8'd0;
            stop_min_r    <= 1'b0;
            result_prev_r <= 1'b0;
            found_r       <= 1'b0;
        end else begin
            result_prev_r <= result;
            if (load_s) begin
                target_r <= target_in;
                wcnt_r   <= 3'd0;
            end else if (wr_s) begin
                wcnt_r <= wcnt_r + 3'd1;
            end
            if (state_r == S_DELAY) begin
                dcnt_r <= dcnt_r + 8'd1;
            end else begin
                dcnt_r <= 8'd0;
            end
            // Set after the first STOP cycle so stop is held for at least two cycles.
            stop_min_r <= (state_r == S_STOP);
            if (load_s) begin
                found_r <= 1'b0;
            end else if (hit_s) begin
                found_r <= 1'b1;
            end
        end
    end

`ifdef TARGET_FEEDER_TIMEOUT_EN
    logic [31:0] tcnt_r;
    logic        timeout_r;

    // RUN cycle counter (zero outside RUN, so it starts from 0 on RUN entry) and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_r    <= 32'd0;
            timeout_r <= 1'b0;
        end else begin
            if (state_r == S_RUN) begin
                tcnt_r <= tcnt_r + 32'd1;
            end else begin
                tcnt_r <= 32'd0;
            end
            if (load_s) begin
                timeout_r <= 1'b0;
            end else if ((state_r == S_RUN) && !rise_s && !abort && tmo_hit_s) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign tmo_hit_s = (tcnt_r == (TIMEOUT_CYCLES - 32'd1));
    assign timeout   = timeout_r;
`else
    assign tmo_hit_s = 1'b0;
    assign timeout   = 1'b0;
`endif

    assign target_ready      = (state_r == S_IDLE) & ~rst;
    assign target_fifo_we    = wr_s;
    assign target_fifo_wdata = target_r[{wcnt_r, 5'd0} +: 32];
    assign start             = (state_r == S_START);
    assign stop              = (state_r == S_STOP);
    assign busy              = (state_r != S_IDLE);
    assign found             = found_r;

endmodule

// File: doc/target_feeder.md
# target_feeder

Host-side producer for the miner's target path. Accepts a 256-bit target in one handshake and serialises it as eight 32-bit words, least-significant word first, into the target async FIFO. It then pulses `start` to the comparator, tracks the run until `result` rises, a host abort arrives, or an optional timeout fires. Finally it drives the `stop`/`stop_ack_comp` handshake to return the comparator to its drained idle state.

## Interface
- `START_DELAY`, 4: cycles between the last FIFO write and the `start` pulse (covers async FIFO crossing latency); legal range 1..255.
- `TIMEOUT_CYCLES`, 32'd1_000_000: RUN-state cycle limit; only used with `TARGET_FEEDER_TIMEOUT_EN`.
- `clk`  in  1  global clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `target_in`  in  256  target value, sampled when `target_valid & target_ready`.
- `target_valid`  in  1  host load request.
- `target_ready`  out  1  high only in IDLE.
- `abort`  in  1  host cancel; level, sampled in PUSH/DELAY/RUN.
- `target_fifo_we`  out  1  target FIFO write enable.
- `target_fifo_wdata`  out  32  target FIFO write data.
- `target_fifo_full`  in  1  target FIFO full.
- `start`  out  1  one-cycle start pulse to comparator.
- `stop`  out  1  stop request to comparator.
- `stop_ack_comp`  in  1  comparator idle/drained acknowledge.
- `result`  in  1  comparator hit flag; sticky on comparator side.
- `found`  out  1  sticky hit status; cleared on next accepted load.
- `timeout`  out  1  sticky timeout status; cleared on next accepted load; constant 0 without macro.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: `target_ready`=1. On `target_valid`, latch `target_in`, clear `found`/`timeout`, clear `wcnt`, go to PUSH.
  - PUSH:
    - `target_fifo_we` = (state==PUSH) & !`target_fifo_full` (combinational). `target_fifo_wdata` = `target_reg[32*wcnt +: 32]`.
    - `wcnt` (3-bit) increments on each write. Write with `wcnt`==7 moves to DELAY.
    - `abort` moves to STOP; partial words remain in the FIFO and this block does not purge them.
  - DELAY: count `START_DELAY` cycles, then go to START. `abort` moves to STOP.
  - START: `start`=1 for exactly one cycle, then go to RUN.
  - RUN:
    - Rising edge of `result` (registered previous value) sets `found`=1 and moves to STOP.
    - Otherwise `abort` moves to STOP.
    - Otherwise, with macro, the timeout condition moves to STOP.
    - If found and abort occur in the same cycle, found has priority: `found` is set, single transition to STOP.
  - STOP: `stop`=1. Held at least 2 cycles and until `stop_ack_comp`==1 is sampled, then go to IDLE with `stop`=0.
- `result` already high on RUN entry (left sticky from a previous job) is not a hit; only a 0→1 transition counts.
- Words are sent LSW first: word k = `target[32k+31:32k]`.

## Timing
- Reset values, applied immediately on `rst` assertion regardless of state:
  - `target_ready`=0 while `rst` is high, 1 the first cycle after release (IDLE).
  - `target_fifo_we`=0, `target_fifo_wdata`=0, `start`=0, `stop`=0, `found`=0, `timeout`=0, `busy`=0.
  - State IDLE; `target_reg`, `wcnt`, delay and timeout counters all 0.
- Reset mid-PUSH or mid-RUN abandons the job. No `stop` is issued; the comparator is expected to share the reset.
- Latency with a non-full FIFO, from load acceptance (cycle 0): words written cycles 1..8, `start` at cycle 9+`START_DELAY`.
- A full FIFO stalls PUSH with no word loss or duplication. `wcnt` holds and `wdata` stays stable while stalled.
- `found` rises 1 cycle after `result` rises. `stop` rises in the same cycle as `found`.
- `target_valid` outside IDLE is ignored; the host must hold it until it sees `target_ready`.

## Configuration
- `TARGET_FEEDER_TIMEOUT_EN` defined:
  - 32-bit counter cleared on RUN entry and incremented each RUN cycle.
  - When count == `TIMEOUT_CYCLES`-1 and no hit: `timeout`=1, go to STOP.
- Not defined: counter removed, RUN waits indefinitely for a hit or `abort`, and `timeout` is tied to 0.

## Test plan
- Load `target_in`=256'h0000_0001_..._0000_0008 (word k = 8-k), FIFO never full → `wdata` sequence 8,7,…,1 on cycles 1..8, then `start` pulse at cycle 13 (`START_DELAY`=4).
- Hold `target_fifo_full`=1 for cycles 3..6 during PUSH → exactly 8 writes in order, no repeats, `start` delayed 4 cycles.
- In RUN, raise `result` → `found`=1 next cycle with `stop`=1; drive `stop_ack_comp` high 3 cycles later → IDLE, `target_ready`=1, `found` stays 1 until the next load.
- `abort` during PUSH after 3 words → no further writes, `stop` held ≥2 cycles until ack, `found`=0.
- `result`=1 held before `start`, never toggling → no hit; with macro and `TIMEOUT_CYCLES`=16 → `timeout`=1 after 16 RUN cycles, then STOP.
- Assert `rst` in RUN with `stop`=1 → all outputs at reset values the same cycle; after release, a new load runs normally.
